// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin arbiter serialising four ATM terminals onto one account store,
// performing READ/DEBIT/CREDIT on a card's balance word with one transaction in flight.
module atm_account_arbiter #(
   parameter int NUM_CARDS = 9,
   parameter int BAL_IDX   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [7:0]  op,
   input  logic [31:0] card,
   input  logic [63:0] amount,
   output logic [3:0]  gnt,
   output logic [3:0]  done,
   output logic [15:0] rdata,
   output logic [7:0]  err,
   output logic [7:0]  mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic [15:0] txn_count
);
   typedef enum logic [2:0] {IDLE, ERR, RD, WAIT, WR, RESP} state_t;
   localparam logic [1:0] OP_DEBIT  = 2'b01;
   localparam logic [1:0] OP_CREDIT = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;
   state_t      state, state_nx;
   logic [1:0]  last_grant, term, pick, cand;
   logic        found;
   logic [1:0]  op_q, op_sel;
   logic [7:0]  card_q, card_sel, err_q;
   logic [15:0] amt_q, amt_sel, res_q;
   logic [16:0] sum;
   logic        bad_card, debit_ok, credit_ok;

   // First requester searching upward from the terminal after the last one served
   always_comb begin
      found = 1'b0;
      pick  = last_grant;
      cand  = '0;
      for (int i = 1; i <= 4; i++) begin
         cand = last_grant + 2'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign op_sel    = op[{pick, 1'b0} +: 2];
   assign card_sel  = card[{pick, 3'b000} +: 8];
   assign amt_sel   = amount[{pick, 4'b0000} +: 16];
   assign bad_card  = card_sel >= 8'(NUM_CARDS);
   assign sum       = {1'b0, mem_rdata} + {1'b0, amt_q};
   assign debit_ok  = op_q == OP_DEBIT && amt_q <= mem_rdata;
   assign credit_ok = op_q == OP_CREDIT && !sum[16];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = !found ? IDLE : (bad_card || op_sel == OP_RSVD) ? ERR : RD;
         ERR:     state_nx = RESP;
         RD:      state_nx = WAIT;
         WAIT:    state_nx = (debit_ok || credit_ok) ? WR : RESP;
         WR:      state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last_grant <= 2'd3;
         term       <= '0;
         op_q       <= '0;
         card_q     <= '0;
         amt_q      <= '0;
         res_q      <= '0;
         err_q      <= '0;
         txn_count  <= '0;
      end else if (state == IDLE && found) begin
         term   <= pick;
         op_q   <= op_sel;
         card_q <= card_sel;
         amt_q  <= amt_sel;
         res_q  <= '0;
         err_q  <= bad_card ? 8'h01 : op_sel == OP_RSVD ? 8'h06 : 8'h00;
      end else if (state == WAIT) begin
         res_q <= debit_ok ? mem_rdata - amt_q : credit_ok ? sum[15:0] : mem_rdata;
         err_q <= (op_q == OP_DEBIT && !debit_ok) ? 8'h03 : (op_q == OP_CREDIT && !credit_ok) ? 8'h05 : 8'h00;
      end else if (state == WR) begin
         txn_count <= txn_count + 16'd1;
      end else if (state == RESP) begin
         last_grant <= term;
      end

   assign gnt       = (state == ERR || state == RD) ? 4'b0001 << term : '0;
   assign done      = state == RESP ? 4'b0001 << term : '0;
   assign rdata     = state == RESP ? res_q : '0;
   assign err       = state == RESP ? err_q : '0;
   assign mem_re    = state == RD;
   assign mem_we    = state == WR;
   assign mem_addr  = (mem_re || mem_we) ? (card_q << 2) + 8'(BAL_IDX) : '0;
   assign mem_wdata = mem_we ? res_q : '0;
endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb_atm_account_arbiter: directed vector table plus reset and round-robin sequences,
// with a behavioural account store attached to the memory port.
module tb_atm_account_arbiter;
   logic        clk = 1'b0, rst_n;
   logic [3:0]  req, gnt, done;
   logic [7:0]  op, err, mem_addr;
   logic [31:0] card;
   logic [63:0] amount;
   logic [15:0] rdata, mem_wdata, mem_rdata, txn_count;
   logic        mem_re, mem_we;
   logic [15:0] mem [256];
   int          checks = 0, errors = 0;
   logic [15:0] exp_cnt = '0;

   typedef struct {
      int          term;
      logic [1:0]  op;
      logic [7:0]  card;
      logic [15:0] amt, bal, exp_rd;
      logic [7:0]  exp_err;
      int          lat;
      bit          we;
   } vec_t;
   vec_t vec [9];

   atm_account_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .card(card), .amount(amount),
      .gnt(gnt), .done(done), .rdata(rdata), .err(err), .mem_addr(mem_addr),
      .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .txn_count(txn_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt != 0) begin
            ok = 1'b1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL gnt_timeout actual=0 expected=grant");
   endtask

   task automatic run(input vec_t v);
      logic [7:0]  a, wa;
      logic [15:0] wd;
      bit          ok, we_seen, coll;
      int          lat;
      a = 8'(v.card * 4 + 1);
      @(negedge clk);
      mem[a] <= v.bal;
      req = '0;
      req[v.term] = 1'b1;
      op[2*v.term +: 2] = v.op;
      card[8*v.term +: 8] = v.card;
      amount[16*v.term +: 16] = v.amt;
      wait_gnt(ok);
      if (!ok) begin
         req = '0;
         return;
      end
      chk("gnt", 32'(gnt), 32'(4'b0001 << v.term));
      chk("mem_re_at_grant", 32'(mem_re), 32'(v.lat > 1));
      req = '0;
      op = '1;
      card = '1;
      amount = '1;
      we_seen = 1'b0;
      coll = 1'b0;
      wd = '0;
      wa = '0;
      for (lat = 1; lat <= 6; lat++) begin
         @(negedge clk);
         if (mem_re && mem_we) coll = 1'b1;
         if (mem_we) begin
            we_seen = 1'b1;
            wd = mem_wdata;
            wa = mem_addr;
         end
         if (done != 0) break;
      end
      chk("latency", 32'(lat), 32'(v.lat));
      chk("done", 32'(done), 32'(4'b0001 << v.term));
      chk("rdata", 32'(rdata), 32'(v.exp_rd));
      chk("err", 32'(err), 32'(v.exp_err));
      chk("mem_we_seen", 32'(we_seen), 32'(v.we));
      chk("re_we_overlap", 32'(coll), 32'(0));
      if (v.we) begin
         chk("mem_wdata", 32'(wd), 32'(v.exp_rd));
         chk("mem_addr_wr", 32'(wa), 32'(a));
         exp_cnt++;
      end
      chk("store", 32'(mem[a]), 32'(v.we ? v.exp_rd : v.bal));
      chk("txn_count", 32'(txn_count), 32'(exp_cnt));
   endtask

   initial begin
      bit ok;
      int lat;
      vec[0] = '{0, 2'b00, 8'd2, 16'h0000, 16'h0100, 16'h0100, 8'h00, 2, 1'b0};
      vec[1] = '{1, 2'b01, 8'd2, 16'h0040, 16'h0100, 16'h00C0, 8'h00, 3, 1'b1};
      vec[2] = '{2, 2'b01, 8'd2, 16'h0200, 16'h00C0, 16'h00C0, 8'h03, 2, 1'b0};
      vec[3] = '{3, 2'b10, 8'd5, 16'h0002, 16'hFFFF, 16'hFFFF, 8'h05, 2, 1'b0};
      vec[4] = '{0, 2'b00, 8'd9, 16'h0000, 16'h1111, 16'h0000, 8'h01, 1, 1'b0};
      vec[5] = '{1, 2'b11, 8'd3, 16'h0001, 16'h2222, 16'h0000, 8'h06, 1, 1'b0};
      vec[6] = '{2, 2'b10, 8'd8, 16'h0001, 16'hFFFE, 16'hFFFF, 8'h00, 3, 1'b1};
      vec[7] = '{3, 2'b01, 8'd0, 16'h0005, 16'h0005, 16'h0000, 8'h00, 3, 1'b1};
      vec[8] = '{0, 2'b10, 8'd1, 16'h0000, 16'h1234, 16'h1234, 8'h00, 3, 1'b1};
      rst_n = 1'b0;
      req = '0;
      op = '0;
      card = '0;
      amount = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt_done", 32'({gnt, done}), 32'(0));
      chk("rst_rdata_err", 32'({rdata, err}), 32'(0));
      chk("rst_mem_port", 32'({mem_addr, mem_re, mem_we, mem_wdata}), 32'(0));
      chk("rst_txn_count", 32'(txn_count), 32'(0));
      rst_n = 1'b1;
      foreach (vec[i]) run(vec[i]);

      // Reset during WAIT of a DEBIT must abandon it without touching the store
      @(negedge clk);
      mem[9] <= 16'h0100;
      req = 4'b0010;
      op = 8'b0000_0100;
      card = 32'h0000_0200;
      amount = 64'h0000_0000_0010_0000;
      wait_gnt(ok);
      chk("rst_case_gnt", 32'(gnt), 32'(4'b0010));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt_done", 32'({gnt, done}), 32'(0));
      chk("midrst_rdata_err", 32'({rdata, err}), 32'(0));
      chk("midrst_mem_port", 32'({mem_addr, mem_re, mem_we, mem_wdata}), 32'(0));
      chk("midrst_txn_count", 32'(txn_count), 32'(0));
      req = '0;
      repeat (3) @(negedge clk);
      chk("midrst_store", 32'(mem[9]), 32'(16'h0100));
      rst_n = 1'b1;
      exp_cnt = '0;

      // All four terminals requesting continuously: strict rotation from terminal 0
      @(negedge clk);
      op = '0;
      card = 32'h0202_0202;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_gnt(ok);
         if (!ok) break;
         chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
         for (lat = 1; lat <= 6; lat++) begin
            @(negedge clk);
            if (done != 0) break;
         end
         chk("rr_done", 32'(done), 32'(4'b0001 << (i % 4)));
      end
      req = '0;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/atm_account_arbiter.md
ATM_ACCOUNT_ARBITER -- requirements
Module: atm_account_arbiter

Interface
REQ-001 SHALL have parameter NUM_CARDS, default 9, number of valid card records in the account store.
REQ-002 SHALL have parameter BAL_IDX, default 1, word offset of the balance within a 4-word card record.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-terminal transaction request; bit i belongs to terminal i.
REQ-006 op  input  8  per-terminal opcode, 2 bits each (bits 2i+1:2i): 00 READ, 01 DEBIT, 10 CREDIT, 11 reserved.
REQ-007 card  input  32  per-terminal card number, 8 bits each (bits 8i+7:8i).
REQ-008 amount  input  64  per-terminal amount, 16 bits each (bits 16i+15:16i).
REQ-009 gnt  output  4  one-hot, one-cycle pulse marking the terminal accepted.
REQ-010 done  output  4  one-hot, one-cycle pulse marking completion for that terminal.
REQ-011 rdata  output  16  resulting balance; valid only while done is nonzero.
REQ-012 err  output  8  completion status; valid only while done is nonzero.
REQ-013 mem_addr  output  8  account-store word address.
REQ-014 mem_re  output  1  account-store read strobe; read data returns one cycle later.
REQ-015 mem_we  output  1  account-store write strobe.
REQ-016 mem_wdata  output  16  account-store write data.
REQ-017 mem_rdata  input  16  account-store read data, valid the cycle after mem_re.
REQ-018 txn_count  output  16  count of committed DEBIT/CREDIT writes.

Function
REQ-019 States SHALL be IDLE, ERR, RD, WAIT, WR and RESP; exactly one transaction SHALL be in flight at any time.
REQ-020 IDLE with req nonzero: the block SHALL grant the first requesting terminal searching upward from last_grant+1 (mod 4), latch that terminal's op, card and amount, and pulse gnt for that terminal during the next cycle.
REQ-021 IDLE grant routing: card >= NUM_CARDS or op = 11 SHALL go to ERR; any other grant SHALL go to RD.
REQ-022 The latched values SHALL be the only operands used; changes to req, op, card or amount after grant SHALL have no effect, and dropping req SHALL NOT abort the transaction.
REQ-023 ERR: no memory access; next state RESP with err = 8'h01 (INVALID_CARD) for a bad card, or 8'h06 for op 11; rdata = 0.
REQ-024 RD: mem_re = 1 and mem_addr = card*4 + BAL_IDX (8-bit result); next state WAIT.
REQ-025 WAIT: the block SHALL capture mem_rdata as old balance B.
REQ-026 WAIT, READ: next state RESP, rdata = B, err = 00.
REQ-027 WAIT, DEBIT with amount <= B: next state WR, write data B - amount.
REQ-028 WAIT, DEBIT with amount > B: next state RESP, err = 8'h03, rdata = B, no write.
REQ-029 WAIT, CREDIT with 17-bit sum B + amount <= 16'hFFFF: next state WR, write data = sum.
REQ-030 WAIT, CREDIT with overflow: next state RESP, err = 8'h05, rdata = B, no write.
REQ-031 WR: mem_we = 1 with the same mem_addr; rdata = new balance; err = 00; txn_count increments (wraps FFFF -> 0000); next state RESP.
REQ-032 RESP: done pulses for the latched terminal for one cycle; last_grant is updated; next state IDLE.
REQ-033 Latency, counting from the gnt cycle k: done at k+1 for the ERR path, k+2 for READ or a rejected DEBIT/CREDIT, and k+3 for a committed DEBIT/CREDIT.
REQ-034 A request still held after its done SHALL re-arbitrate in IDLE; the round-robin order SHALL guarantee each requester a grant within 4 transactions.
REQ-035 mem_re and mem_we SHALL never be high in the same cycle; both SHALL be 0 outside RD and WR.

Reset
REQ-036 While rst_n = 0: state = IDLE, last_grant = 3 (so terminal 0 has first priority), and gnt, done, rdata, err, mem_addr, mem_re, mem_we, mem_wdata and txn_count all = 0.
REQ-037 Reset asserted mid-transaction SHALL abandon it with no write, no done pulse, and an unchanged account store.

Verification
REQ-038 Store balance card 2 = 16'h0100; terminal 0 READ card 2 -> gnt=0001 at k, done=0001 at k+2, rdata=0100, err=00.
REQ-039 Terminal 1 DEBIT card 2 amount 0x0040 -> mem_we at k+2 with wdata 0x00C0, done=0010 at k+3, txn_count=1.
REQ-040 DEBIT 0x0200 against balance 0x00C0 -> err=03, rdata=00C0, no mem_we.
REQ-041 CREDIT 0x0002 against balance 0xFFFF -> err=05, no write; card 9 READ -> err=01, done at k+1, no mem_re.
REQ-042 req=1111 held continuously -> grants in order 0,1,2,3,0; no terminal waits more than 4 transactions.
REQ-043 Assert rst_n=0 during WAIT of a DEBIT -> no mem_we, all outputs 0, next grant goes to terminal 0.
